// File: rtl/pgm_ddram_arbiter_pkg.sv
// Shared types and address helpers for the PGM DDRAM arbiter and read-cache blocks.
package pgm_ddr_pkg;

    typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} arb_state_t;

    localparam logic [28:0] ADDR_BASE_DEF = 29'h0600_0000;
    localparam int          BYTE_AW       = 27;

    // 8-byte word address inside the ROM region; the add wraps modulo 2^29.
    function automatic logic [28:0] word_addr(input logic [28:0] base, input logic [23:0] word);
        return base + {5'b0, word};
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] halfword);
        return 8'b11 << {halfword, 1'b0};
    endfunction

endpackage

// File: rtl/pgm_ddram_arbiter_if.sv
// Client-side bus (ioctl writer + read requesters) and DDRAM Avalon-side bus.
interface pgm_client_if #(parameter int N_RD = 3);
    logic              wr_req;
    logic [26:0]       wr_addr;
    logic [15:0]       wr_data;
    logic              wr_wait;
    logic [N_RD-1:0]   rd_req;
    logic [N_RD*27-1:0] rd_addr;
    logic [N_RD-1:0]   rd_ack;
    logic [63:0]       rd_data;
    logic              rd_err;

    modport master (output wr_req, wr_addr, wr_data, rd_req, rd_addr,
                    input  wr_wait, rd_ack, rd_data, rd_err);
    modport slave  (input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
                    output wr_wait, rd_ack, rd_data, rd_err);
endinterface

interface pgm_ddram_if;
    logic [28:0] ddram_addr;
    logic        ddram_rd;
    logic        ddram_we;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic        ddram_busy;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    modport master (output ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be,
                    input  ddram_busy, ddram_dout, ddram_dout_ready);
    modport slave  (input  ddram_addr, ddram_rd, ddram_we, ddram_din, ddram_be,
                    output ddram_busy, ddram_dout, ddram_dout_ready);
endinterface

// File: rtl/pgm_ddram_arbiter_rr.sv
// Round-robin picker: search starts at ptr_q, which advances past each granted index.
module pgm_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          grant_en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en && any)
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/pgm_ddram_arbiter.sv
// Shares one DDRAM Avalon port between the ioctl ROM writer and N_RD single-beat readers.
module pgm_ddram_arbiter
    import pgm_ddr_pkg::*;
#(
    parameter int          N_RD       = 3,
    parameter logic [28:0] ADDR_BASE  = ADDR_BASE_DEF,
    parameter int          RD_TIMEOUT = 1023
) (
    input  logic           fixed_50m_clk,
    input  logic           reset,
    pgm_client_if.slave    cl,
    pgm_ddram_if.master    ddr,
    output logic           busy_led
);
    localparam int IW = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic [26:1]      hold_addr_q, hold_addr_d;
    logic [15:0]      hold_data_q, hold_data_d;
    logic             wr_wait_q, wr_wait_d;
    logic [IW-1:0]    req_idx_q, req_idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [28:0]      addr_q, addr_d;
    logic             rd_q, rd_d, we_q, we_d;
    logic [63:0]      din_q, din_d;
    logic [7:0]       be_q, be_d;
    logic [N_RD-1:0]  rd_ack_q, rd_ack_d;
    logic [63:0]      rd_data_q, rd_data_d;
    logic             rd_err_q, rd_err_d;
    logic             busy_led_q, busy_led_d;

    logic [N_RD-1:0]  rr_grant;
    logic [IW-1:0]    rr_idx;
    logic             rr_any;
    logic             rr_en;
    logic [23:0]      rd_word;

    // A full write holder always beats pending reads in IDLE.
    assign rr_en   = (state_q == IDLE) && !hold_full_q;
    assign rd_word = cl.rd_addr[int'(rr_idx)*27 + 3 +: 24];

    pgm_rr_arbiter #(.N(N_RD), .IW(IW)) u_rr (
        .clk       (fixed_50m_clk),
        .rst       (reset),
        .req       (cl.rd_req),
        .grant_en  (rr_en),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        req_idx_d   = req_idx_q;
        timer_d     = timer_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        we_d        = we_q;
        din_d       = din_q;
        be_d        = be_q;
        rd_ack_d    = '0;
        rd_data_d   = rd_data_q;
        rd_err_d    = rd_err_q;

        // A strobe arriving while the holder is full is dropped.
        if (cl.wr_req && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_addr_d = cl.wr_addr[26:1];
            hold_data_d = cl.wr_data;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = WR_ISSUE;
                    we_d    = 1'b1;
                    addr_d  = word_addr(ADDR_BASE, hold_addr_q[26:3]);
                    din_d   = {4{hold_data_q}};
                    be_d    = byte_en(hold_addr_q[2:1]);
                end else if (rr_any) begin
                    state_d   = RD_ISSUE;
                    rd_d      = 1'b1;
                    addr_d    = word_addr(ADDR_BASE, rd_word);
                    be_d      = 8'hFF;
                    req_idx_d = rr_idx;
                end
            end
            WR_ISSUE: begin
                if (!ddr.ddram_busy) begin
                    we_d        = 1'b0;
                    hold_full_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!ddr.ddram_busy) begin
                    rd_d    = 1'b0;
                    timer_d = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (ddr.ddram_dout_ready) begin
                    rd_ack_d  = N_RD'(1) << req_idx_q;
                    rd_data_d = ddr.ddram_dout;
                    state_d   = IDLE;
                end else if (timer_q == TW'(RD_TIMEOUT)) begin
                    rd_ack_d  = N_RD'(1) << req_idx_q;
                    rd_data_d = '1;
                    rd_err_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_wait_d  = hold_full_d;
        busy_led_d = (state_d != IDLE);
    end

    always_ff @(posedge fixed_50m_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wr_wait_q   <= 1'b0;
            req_idx_q   <= '0;
            timer_q     <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            din_q       <= '0;
            be_q        <= '0;
            rd_ack_q    <= '0;
            rd_data_q   <= '0;
            rd_err_q    <= 1'b0;
            busy_led_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wr_wait_q   <= wr_wait_d;
            req_idx_q   <= req_idx_d;
            timer_q     <= timer_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            din_q       <= din_d;
            be_q        <= be_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
            rd_err_q    <= rd_err_d;
            busy_led_q  <= busy_led_d;
        end
    end

    assign cl.wr_wait     = wr_wait_q;
    assign cl.rd_ack      = rd_ack_q;
    assign cl.rd_data     = rd_data_q;
    assign cl.rd_err      = rd_err_q;
    assign ddr.ddram_addr = addr_q;
    assign ddr.ddram_rd   = rd_q;
    assign ddr.ddram_we   = we_q;
    assign ddr.ddram_din  = din_q;
    assign ddr.ddram_be   = be_q;
    assign busy_led       = busy_led_q;
endmodule
